// File: rtl/counter_sequencer.sv
// counter_sequencer: issues load / inc / dec commands to the 6-bit up/down
// counter for one run request. It keeps a shadow copy of the counter value
// that tracks every command it drives.
module counter_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_start,
  input  logic [5:0] req_count,
  input  logic       req_dir,
  input  logic       abort,
  output logic [2:0] ctr_control,
  output logic [5:0] ctr_data,
  output logic       busy,
  output logic       done,
  output logic [5:0] shadow,
  output logic       shadow_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_DONE
  } state_e;

  localparam logic [2:0] CTL_HOLD = 3'b000;
  localparam logic [2:0] CTL_LOAD = 3'b100;
  localparam logic [2:0] CTL_INC  = 3'b010;
  localparam logic [2:0] CTL_DEC  = 3'b011;

  state_e     state_q, state_d;
  logic [5:0] remaining_q, remaining_d;
  logic       dir_q, dir_d;
  logic [5:0] data_q, data_d;
  logic [5:0] shadow_q, shadow_d;
  logic       shadow_valid_q, shadow_valid_d;

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    data_d      = data_q;
    ctr_control = CTL_HOLD;
    busy        = 1'b0;
    done        = 1'b0;
    req_ready   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Ready is masked by reset so no request is ever acknowledged on a
        // reset edge.
        req_ready = !reset;
        if (req_valid && !reset) begin
          state_d     = S_LOAD;
          data_d      = req_start;
          remaining_d = req_count;
          dir_d       = req_dir;
        end
      end
      S_LOAD: begin
        ctr_control = CTL_LOAD;
        busy        = 1'b1;
        if (abort)                   state_d = S_IDLE;
        else if (remaining_q != 6'd0) state_d = S_STEP;
        else                          state_d = S_DONE;
      end
      S_STEP: begin
        ctr_control = dir_q ? CTL_DEC : CTL_INC;
        busy        = 1'b1;
        remaining_d = remaining_q - 6'd1;
        // Abort wins over completion, so an aborted last step gives no done.
        if (abort)                    state_d = S_IDLE;
        else if (remaining_q == 6'd1) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shadow follows whatever command is on the bus this cycle, mod 64.
  always_comb begin
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    unique case (ctr_control)
      CTL_LOAD: begin
        shadow_d       = data_q;
        shadow_valid_d = 1'b1;
      end
      CTL_INC: shadow_d = shadow_q + 6'd1;
      CTL_DEC: shadow_d = shadow_q - 6'd1;
      default: shadow_d = shadow_q;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (reset) begin
      state_q        <= S_IDLE;
      remaining_q    <= 6'd0;
      dir_q          <= 1'b0;
      data_q         <= 6'd0;
      shadow_q       <= 6'd0;
      shadow_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      dir_q          <= dir_d;
      data_q         <= data_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  // The load value register doubles as the data bus, so it holds the last
  // loaded value outside LOAD.
  assign ctr_data     = data_q;
  assign shadow       = shadow_q;
  assign shadow_valid = shadow_valid_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: the driver pushes the expected
// per-cycle command stream for each accepted run; a monitor pops and compares
// whenever the sequencer is busy or signals done.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_start;
  logic [5:0] req_count;
  logic       req_dir;
  logic       abort;
  logic [2:0] ctr_control;
  logic [5:0] ctr_data;
  logic       busy;
  logic       done;
  logic [5:0] shadow;
  logic       shadow_valid;

  // One expected active cycle: the command on the bus, and either the data
  // bus value (load cycle) or the shadow value (step / done cycle).
  typedef struct {
    logic [2:0] ctrl;
    logic [5:0] val;
  } item_t;

  item_t exp_q[$];
  item_t mon_item;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    last_accept = 0;
  int    prev_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_start    (req_start),
    .req_count    (req_count),
    .req_dir      (req_dir),
    .abort        (abort),
    .ctr_control  (ctr_control),
    .ctr_data     (ctr_data),
    .busy         (busy),
    .done         (done),
    .shadow       (shadow),
    .shadow_valid (shadow_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model of one run: load, n steps, optional done cycle.
  function automatic void push_run(input logic [5:0] s, input int n,
                                   input logic d, input bit full);
    logic [5:0] sh;
    sh = s;
    exp_q.push_back('{3'b100, s});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{(d ? 3'b011 : 3'b010), sh});
      sh = d ? sh - 6'd1 : sh + 6'd1;
    end
    if (full) exp_q.push_back('{3'b000, sh});
  endfunction

  // Called at a negedge. Waits for ready (driving junk data meanwhile),
  // issues the request, pushes its expectation, returns at the LOAD negedge.
  task automatic send(input logic [5:0] s, input logic [5:0] c, input logic d,
                      input int n_push, input bit full, input bit hold,
                      input bit check_gap);
    int budget;
    budget = 100;
    while (!req_ready) begin
      if (budget == 0) begin
        check("ready_timeout", int'(req_ready), 1);
        return;
      end
      budget--;
      req_start = 6'(cyc * 5 + 3);
      req_count = 6'(cyc + 1);
      req_dir   = cyc[0];
      @(negedge clk);
    end
    if (check_gap) check("request_spacing", cyc - last_accept, prev_count + 3);
    last_accept = cyc;
    prev_count  = int'(c);
    req_start   = s;
    req_count   = c;
    req_dir     = d;
    req_valid   = 1'b1;
    @(posedge clk);
    push_run(s, n_push, d, full);
    @(negedge clk);
    req_valid = hold;
    req_start = 6'(s + 6'd17);
    req_count = 6'(c + 6'd9);
    req_dir   = ~d;
  endtask

  task automatic wait_done();
    int budget;
    budget = 100;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("done_seen", int'(done), 1);
    @(negedge clk);
    check("ready_after_done", int'(req_ready), 1);
    check("hold_after_done", int'(ctr_control), 0);
  endtask

  // Monitor: compare every active cycle against the scoreboard.
  always @(negedge clk) begin
    if (busy || done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_busy_done", int'({busy, done}), 0);
      end else begin
        mon_item = exp_q.pop_front();
        check("ctr_control", int'(ctr_control), int'(mon_item.ctrl));
        if (mon_item.ctrl == 3'b100) begin
          check("ctr_data", int'(ctr_data), int'(mon_item.val));
        end else begin
          check("shadow", int'(shadow), int'(mon_item.val));
          check("shadow_valid", int'(shadow_valid), 1);
        end
        check("done", int'(done), int'(mon_item.ctrl == 3'b000));
        check("busy", int'(busy), int'(mon_item.ctrl != 3'b000));
      end
    end else begin
      check("idle_ctrl", int'(ctr_control), 0);
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_start = 6'd0;
    req_count = 6'd0;
    req_dir   = 1'b0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", int'(ctr_control), 0);
    check("rst_data", int'(ctr_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_shadow", int'(shadow), 0);
    check("rst_shadow_valid", int'(shadow_valid), 0);
    check("rst_ready", int'(req_ready), 0);
    reset = 1'b0;
    #1;
    check("ready_idle", int'(req_ready), 1);
    @(negedge clk);

    // Up run: 10 -> 13.
    send(6'd10, 6'd3, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    wait_done();
    // Down run wrapping through zero: 1 -> 62.
    send(6'd1, 6'd3, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    wait_done();
    // Zero count, then up wrap 63 -> 0.
    send(6'd45, 6'd0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    send(6'd63, 6'd1, 1'b0, 1, 1'b1, 1'b0, 1'b0);

    // Abort in the third STEP cycle: three steps applied, shadow 23.
    send(6'd20, 6'd10, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_shadow", int'(shadow), 23);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_ready", int'(req_ready), 1);
    send(6'd30, 6'd2, 1'b1, 2, 1'b1, 1'b0, 1'b0);
    wait_done();

    // Reset during STEP, with a request held alongside reset.
    send(6'd5, 6'd8, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_start = 6'd33;
    req_count = 6'd4;
    @(negedge clk);
    check("mid_rst_shadow", int'(shadow), 0);
    check("mid_rst_shadow_valid", int'(shadow_valid), 0);
    check("mid_rst_ctrl", int'(ctr_control), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_data", int'(ctr_data), 0);
    repeat (2) begin
      check("rst_hold_ready", int'(req_ready), 0);
      @(negedge clk);
      check("rst_hold_busy", int'(busy), 0);
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    // Handshake: valid held high with junk data between back-to-back runs.
    send(6'd7, 6'd2, 1'b0, 2, 1'b1, 1'b1, 1'b0);
    send(6'd50, 6'd1, 1'b1, 1, 1'b1, 1'b1, 1'b1);
    send(6'd12, 6'd0, 1'b0, 0, 1'b1, 1'b0, 1'b1);

    repeat (6) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
